// File: rtl/sequence_detector.sv
// Serial detector for the pattern 0,1,{0}*,1 (non-overlapping) with a two-digit BCD
// detection counter, its binary mirror, and active-low seven-segment decodes.
module sequence_detector (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       sig_to_test,
  output logic [7:0] disp0,
  output logic [7:0] disp1,
  output logic       z,
  output logic [6:0] count_detect
);

  typedef enum logic [2:0] {
    START  = 3'd0,
    GOT0   = 3'd1,
    GOT01  = 3'd2,
    GOT010 = 3'd3
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [3:0] ones;
  logic [3:0] tens;

  function automatic logic [7:0] seg_decode(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= START;
    else      state <= next_state;
  end

  // Any completed match returns to START so its final 1 cannot seed the next match.
  always_comb begin
    next_state = START;
    z          = 1'b0;
    case (state)
      START:  next_state = sig_to_test ? START : GOT0;
      GOT0:   next_state = sig_to_test ? GOT01 : GOT0;
      GOT01, GOT010: begin
        if (sig_to_test) begin
          next_state = START;
          z          = rst;
        end else begin
          next_state = GOT010;
        end
      end
      default: next_state = START;
    endcase
  end

  // BCD count and its binary mirror advance together, wrapping 99 -> 00.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones         <= 4'd0;
      tens         <= 4'd0;
      count_detect <= 7'd0;
    end else if (z && ena) begin
      if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
      count_detect <= (ones == 4'd9 && tens == 4'd9) ? 7'd0 : count_detect + 7'd1;
    end
  end

  assign disp0 = seg_decode(ones);
  assign disp1 = seg_decode(tens);

endmodule

// File: tb/tb_sequence_detector.sv
// Directed self-checking bench for sequence_detector: z is checked mid-cycle,
// the count and displays just after each rising edge.
module tb_sequence_detector;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       sig_to_test;
  logic [7:0] disp0;
  logic [7:0] disp1;
  logic       z;
  logic [6:0] count_detect;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  logic [7:0] seg_code [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  sequence_detector dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .sig_to_test  (sig_to_test),
    .disp0        (disp0),
    .disp1        (disp1),
    .z            (z),
    .count_detect (count_detect)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one bit, check z before the edge, then the count/displays after it.
  task automatic applyStimulus(input logic bit_in, input logic exp_z, input string tag);
    @(negedge clk);
    sig_to_test = bit_in;
    #1;
    checkOutput({tag, "_z"}, 32'(z), 32'(exp_z));
    @(posedge clk);
    if (exp_z && ena) exp_count = (exp_count + 1) % 100;
    #1;
    checkOutput({tag, "_cnt"}, 32'(count_detect), 32'(exp_count));
    checkOutput({tag, "_d0"}, 32'(disp0), 32'(seg_code[exp_count % 10]));
    checkOutput({tag, "_d1"}, 32'(disp1), 32'(seg_code[exp_count / 10]));
  endtask

  initial begin
    string stream;
    string zexp;
    rst         = 1'b0;
    ena         = 1'b1;
    sig_to_test = 1'b1;

    // Reset holds everything cleared across clock edges.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_z", 32'(z), 32'd0);
    checkOutput("rst_cnt", 32'(count_detect), 32'd0);
    checkOutput("rst_d0", 32'(disp0), 32'hC0);
    checkOutput("rst_d1", 32'(disp1), 32'hC0);

    @(negedge clk);
    rst = 1'b1;

    stream = "000100110001011101010011";
    zexp   = "000000100000010000010001";
    for (int i = 0; i < 24; i++)
      applyStimulus(stream[i] == "1", zexp[i] == "1", $sformatf("stream%0d", i));
    checkOutput("stream_cnt", 32'(count_detect), 32'd4);
    checkOutput("stream_d0", 32'(disp0), 32'h99);
    checkOutput("stream_d1", 32'(disp1), 32'hC0);

    // Zero-zeros match, then a trailing 1 must not re-trigger.
    applyStimulus(1'b0, 1'b0, "zz0");
    applyStimulus(1'b1, 1'b0, "zz1");
    applyStimulus(1'b1, 1'b1, "zz2");
    applyStimulus(1'b1, 1'b0, "zz3");
    checkOutput("zz_cnt", 32'(count_detect), 32'd5);

    // Disabled counting: detection still flags, count holds.
    ena = 1'b0;
    applyStimulus(1'b0, 1'b0, "ena0_0");
    applyStimulus(1'b1, 1'b0, "ena0_1");
    applyStimulus(1'b0, 1'b0, "ena0_2");
    applyStimulus(1'b1, 1'b1, "ena0_3");
    checkOutput("ena0_cnt", 32'(count_detect), 32'd5);
    ena = 1'b1;
    applyStimulus(1'b0, 1'b0, "ena1_0");
    applyStimulus(1'b1, 1'b0, "ena1_1");
    applyStimulus(1'b0, 1'b0, "ena1_2");
    applyStimulus(1'b1, 1'b1, "ena1_3");
    checkOutput("ena1_cnt", 32'(count_detect), 32'd6);

    // Mid-pattern reset: z drops asynchronously, progress and count are cleared.
    applyStimulus(1'b0, 1'b0, "mid0");
    applyStimulus(1'b1, 1'b0, "mid1");
    @(negedge clk);
    sig_to_test = 1'b1;
    #1;
    checkOutput("mid_z_pre", 32'(z), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("mid_z_rst", 32'(z), 32'd0);
    checkOutput("mid_cnt_rst", 32'(count_detect), 32'd0);
    checkOutput("mid_d0_rst", 32'(disp0), 32'hC0);
    #1;
    rst = 1'b1;
    exp_count = 0;
    applyStimulus(1'b1, 1'b0, "mid2");
    checkOutput("mid_cnt", 32'(count_detect), 32'd0);

    // Wrap: 10 detections show "10", 100 detections roll back to "00".
    for (int n = 0; n < 100; n++) begin
      applyStimulus(1'b0, 1'b0, $sformatf("wrap%0d_a", n));
      applyStimulus(1'b1, 1'b0, $sformatf("wrap%0d_b", n));
      applyStimulus(1'b1, 1'b1, $sformatf("wrap%0d_c", n));
      if (n == 9) begin
        checkOutput("wrap10_cnt", 32'(count_detect), 32'd10);
        checkOutput("wrap10_d0", 32'(disp0), 32'hC0);
        checkOutput("wrap10_d1", 32'(disp1), 32'hF9);
      end
      if (n == 98) begin
        checkOutput("wrap99_cnt", 32'(count_detect), 32'd99);
        checkOutput("wrap99_d0", 32'(disp0), 32'h90);
        checkOutput("wrap99_d1", 32'(disp1), 32'h90);
      end
    end
    checkOutput("wrap100_cnt", 32'(count_detect), 32'd0);
    checkOutput("wrap100_d0", 32'(disp0), 32'hC0);
    checkOutput("wrap100_d1", 32'(disp1), 32'hC0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sequence_detector.md
SEQUENCE_DETECTOR -- requirements
Module: sequence_detector

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 ena  input  1  counter enable; 1 = count detections, 0 = hold the count.
REQ-005 sig_to_test  input  1  serial bit stream, one bit sampled per rising clk edge.
REQ-006 disp0  output  8  seven-segment pattern for the ones digit of the count.
REQ-007 disp1  output  8  seven-segment pattern for the tens digit of the count.
REQ-008 z  output  1  Mealy detection flag.
REQ-009 count_detect  output  7  binary detection count, 0..99.

Function
REQ-010 The block SHALL detect the pattern 0,1,{0}*,1, where {0}* is zero or more zeros, and non-overlapping matches only.
REQ-011 The FSM SHALL use 3-bit state encoding with four states: START (no progress), GOT0 (a 0 was seen), GOT01 (0 then 1 seen), GOT010 (01 followed by one or more 0s).
REQ-012 START: input 0 -> GOT0; input 1 -> START.
REQ-013 GOT0: input 0 -> GOT0; input 1 -> GOT01.
REQ-014 GOT01: input 0 -> GOT010; input 1 -> START with z=1.
REQ-015 GOT010: input 0 -> GOT010; input 1 -> START with z=1.
REQ-016 Unused state codes SHALL transition to START on the next edge with z=0.
REQ-017 z SHALL be combinational: z=1 exactly when the state is GOT01 or GOT010, sig_to_test=1, and rst=1. z SHALL NOT depend on ena.
REQ-018 The final 1 of a match SHALL NOT start a new match; the FSM SHALL return to START after each detection.
REQ-019 The count SHALL be held internally as two BCD digits, ones and tens.
REQ-020 On a rising edge where z=1 and ena=1, the count SHALL increment by 1. It SHALL wrap from 99 to 00.
REQ-021 When ena=0, the count SHALL hold and the FSM SHALL keep running normally.
REQ-022 count_detect SHALL be the registered binary value of the count, equal to tens*10+ones.
REQ-023 disp0 and disp1 SHALL be combinational decodes of the registered digits, active-low, bit order {dp,g,f,e,d,c,b,a}, with dp always 1.
REQ-024 Digit codes SHALL be: 0=C0h, 1=F9h, 2=A4h, 3=B0h, 4=99h, 5=92h, 6=82h, 7=F8h, 8=80h, 9=90h.
REQ-025 Latency SHALL be: z asserts in the same cycle as the completing 1; count, count_detect and displays update after the next rising edge.

Reset
REQ-026 While rst=0, the state SHALL be START, the count 00, count_detect=0, disp0=disp1=C0h, and z=0, independent of clk.
REQ-027 Reset asserted mid-pattern SHALL discard partial progress; the first edge after release SHALL be evaluated from START.

Verification
REQ-028 Reset: rst=0 with any inputs -> z=0, count_detect=0, disp0=C0h, disp1=C0h.
REQ-029 Stream 000100110001011101010011 (leftmost bit first), ena=1 -> z pulses on bits 6, 13, 19 and 23 (0-based). Final count_detect=4, disp0=99h, disp1=C0h.
REQ-030 Input 011 -> one detection on the third bit (zero-zeros case). A following 1 -> no second detection.
REQ-031 ena=0, input 0101 -> z pulses on the last bit and count_detect is unchanged. ena=1 with a repeat -> count +1.
REQ-032 Wrap: 10 detections -> disp1=F9h, disp0=C0h. 100 detections -> count_detect=0, disp0=disp1=C0h.
REQ-033 Reset mid-pattern: drive 01, pulse rst low, then drive 1 -> z=0 and no count change.
